// File: rtl/axi_sram_slave.sv
// AXI4-style SRAM responder: independent read (AR/R) and write (AW/W/B) engines
// sharing one 64-bit word array, with FIXED/INCR bursts, byte strobes and SLVERR.
module axi_sram_slave #(
  parameter int                 ADDR_W    = 32,
  parameter int                 DEPTH     = 4096,
  parameter logic [ADDR_W-1:0]  BASE_ADDR = 32'h8000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] araddr,
  input  logic              arvalid,
  input  logic [1:0]        arburst,
  input  logic [7:0]        arlen,
  input  logic [2:0]        arsize,
  output logic              arready,
  output logic [63:0]       rdata,
  output logic [1:0]        rresp,
  output logic              rvalid,
  output logic              rlast,
  input  logic              rready,
  input  logic [ADDR_W-1:0] awaddr,
  input  logic              awvalid,
  input  logic [1:0]        awburst,
  input  logic [7:0]        awlen,
  output logic              awready,
  input  logic [63:0]       wdata,
  input  logic              wlast,
  input  logic [7:0]        wstrb,
  input  logic              wvalid,
  output logic              wready,
  output logic [1:0]        bresp,
  output logic              bvalid,
  input  logic              bready
);

  localparam int               IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] SPAN = ADDR_W'(8 * DEPTH);

  // Offset arithmetic wraps, so addresses below BASE_ADDR land far above SPAN.
  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return (a - BASE_ADDR) < SPAN;
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
    return IDX_W'((a - BASE_ADDR) >> 3);
  endfunction

  logic [63:0] mem [DEPTH];
  logic [63:0] ram_q;

  // ---------------- read channel ----------------
  typedef enum logic {R_IDLE, R_DATA} r_state_t;
  r_state_t          r_state_reg, r_state_next;
  logic [ADDR_W-1:0] raddr_reg;
  logic [7:0]        rlen_reg, rcnt_reg;
  logic [1:0]        rburst_reg;
  logic [2:0]        rsize_reg;
  logic              rerr_reg;

  logic              ar_hs, r_hs, r_final, rd_load, rd_err;
  logic [ADDR_W-1:0] raddr_step, rd_addr;
  logic [1:0]        rd_burst;

  assign arready    = rst && (r_state_reg == R_IDLE);
  assign rvalid     = (r_state_reg == R_DATA);
  assign ar_hs      = arvalid && arready;
  assign r_hs       = rvalid && rready;
  assign r_final    = (rcnt_reg == rlen_reg);
  assign raddr_step = (rburst_reg == 2'b01) ? raddr_reg + (ADDR_W'(1) << rsize_reg) : raddr_reg;
  assign rd_load    = ar_hs || (r_hs && !r_final);
  assign rd_addr    = ar_hs ? araddr : raddr_step;
  assign rd_burst   = ar_hs ? arburst : rburst_reg;
  assign rd_err     = !in_range(rd_addr) || rd_burst[1];

  assign rlast = rvalid && r_final;
  assign rresp = (rvalid && rerr_reg) ? 2'b10 : 2'b00;
  assign rdata = (rvalid && !rerr_reg) ? ram_q : 64'h0;

  always_comb begin
    r_state_next = r_state_reg;
    case (r_state_reg)
      R_IDLE:  if (ar_hs) r_state_next = R_DATA;
      R_DATA:  if (r_hs && r_final) r_state_next = R_IDLE;
      default: r_state_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state_reg <= R_IDLE;
      raddr_reg   <= '0;
      rlen_reg    <= '0;
      rcnt_reg    <= '0;
      rburst_reg  <= '0;
      rsize_reg   <= '0;
      rerr_reg    <= 1'b0;
    end else begin
      r_state_reg <= r_state_next;
      if (ar_hs) begin
        raddr_reg  <= araddr;
        rlen_reg   <= arlen;
        rburst_reg <= arburst;
        rsize_reg  <= arsize;
        rcnt_reg   <= '0;
        rerr_reg   <= rd_err;
      end else if (r_hs && !r_final) begin
        raddr_reg <= raddr_step;
        rcnt_reg  <= rcnt_reg + 8'd1;
        rerr_reg  <= rd_err;
      end
    end
  end

  // Registered read kept free of reset so it maps onto the RAM output register.
  always_ff @(posedge clk) begin
    if (rd_load) ram_q <= mem[word_idx(rd_addr)];
  end

  // ---------------- write channel ----------------
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  w_state_t          w_state_reg, w_state_next;
  logic [ADDR_W-1:0] waddr_reg;
  logic [7:0]        wlen_reg, wcnt_reg;
  logic [1:0]        wburst_reg;
  logic              werr_reg;

  logic aw_hs, w_hs, w_final, w_ok, mem_we;

  assign awready = rst && (w_state_reg == W_IDLE);
  assign wready  = (w_state_reg == W_DATA);
  assign bvalid  = (w_state_reg == W_RESP);
  assign bresp   = (bvalid && werr_reg) ? 2'b10 : 2'b00;
  assign aw_hs   = awvalid && awready;
  assign w_hs    = wvalid && wready;
  assign w_final = (wcnt_reg == wlen_reg);
  assign w_ok    = in_range(waddr_reg) && !wburst_reg[1];
  assign mem_we  = w_hs && w_ok;

  always_comb begin
    w_state_next = w_state_reg;
    case (w_state_reg)
      W_IDLE:  if (aw_hs) w_state_next = W_DATA;
      W_DATA:  if (w_hs && (wlast || w_final)) w_state_next = W_RESP;
      W_RESP:  if (bready) w_state_next = W_IDLE;
      default: w_state_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_state_reg <= W_IDLE;
      waddr_reg   <= '0;
      wlen_reg    <= '0;
      wcnt_reg    <= '0;
      wburst_reg  <= '0;
      werr_reg    <= 1'b0;
    end else begin
      w_state_reg <= w_state_next;
      if (aw_hs) begin
        waddr_reg  <= awaddr;
        wlen_reg   <= awlen;
        wburst_reg <= awburst;
        wcnt_reg   <= '0;
        werr_reg   <= 1'b0;
      end else if (w_hs) begin
        if (wburst_reg == 2'b01) waddr_reg <= waddr_reg + ADDR_W'(8);
        wcnt_reg <= wcnt_reg + 8'd1;
        // A wlast that disagrees with the beat count is flagged whichever side is early.
        werr_reg <= werr_reg | !w_ok | (wlast ^ w_final);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 8; i++) begin
        if (wstrb[i]) mem[word_idx(waddr_reg)][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Scoreboard bench for axi_sram_slave: drivers push expected R beats / B responses,
// a negedge monitor pops and compares whenever a handshake is presented.
module tb_axi_sram_slave;
  logic        clk = 0;
  logic        rst = 0;
  logic [31:0] araddr = '0, awaddr = '0;
  logic        arvalid = 0, awvalid = 0, rready = 0, bready = 0;
  logic [1:0]  arburst = '0, awburst = '0;
  logic [7:0]  arlen = '0, awlen = '0;
  logic [2:0]  arsize = '0;
  logic        arready, rvalid, rlast, awready, wready, bvalid;
  logic [63:0] rdata;
  logic [1:0]  rresp, bresp;
  logic [63:0] wdata = '0;
  logic        wlast = 0, wvalid = 0;
  logic [7:0]  wstrb = '0;

  axi_sram_slave dut (
    .clk(clk), .rst(rst),
    .araddr(araddr), .arvalid(arvalid), .arburst(arburst), .arlen(arlen), .arsize(arsize),
    .arready(arready), .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rlast(rlast),
    .rready(rready), .awaddr(awaddr), .awvalid(awvalid), .awburst(awburst), .awlen(awlen),
    .awready(awready), .wdata(wdata), .wlast(wlast), .wstrb(wstrb), .wvalid(wvalid),
    .wready(wready), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
  } rbeat_t;

  rbeat_t      rq[$];
  logic [1:0]  bq[$];
  int          checks = 0, errors = 0;
  logic [63:0] wd [8];
  logic [7:0]  ws [8];
  time         ar_time, aw_time;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic expire(input string name);
    checks++;
    errors++;
    $display("FAIL %s: no handshake within cycle budget", name);
  endtask

  function automatic void push_r(input logic [63:0] d, input logic [1:0] r, input logic l);
    rbeat_t e;
    e.data = d; e.resp = r; e.last = l;
    rq.push_back(e);
  endfunction

  // Monitor: compares every presented R beat / B response and checks stall stability.
  rbeat_t     r_held;
  logic       r_stall = 0, b_stall = 0;
  logic [1:0] b_held;
  always @(negedge clk) begin
    if (!rst) begin
      r_stall = 0;
      b_stall = 0;
    end else begin
      if (r_stall) chk("r_stable", {rvalid, rdata, rresp, rlast}, {1'b1, r_held});
      if (rvalid && rready) begin
        rbeat_t e;
        checks++;
        if (rq.size() == 0) begin
          errors++;
          $display("FAIL r_unexpected: got data=%h resp=%b last=%b, required none", rdata, rresp, rlast);
        end else begin
          e = rq.pop_front();
          $display("R beat data=%h resp=%b last=%b", rdata, rresp, rlast);
          if ({rdata, rresp, rlast} !== e) begin
            errors++;
            $display("FAIL r_beat: got data=%h resp=%b last=%b, expected data=%h resp=%b last=%b",
                     rdata, rresp, rlast, e.data, e.resp, e.last);
          end
        end
        r_stall = 0;
      end else if (rvalid) begin
        r_stall = 1;
        r_held  = {rdata, rresp, rlast};
      end else begin
        r_stall = 0;
      end

      if (b_stall) chk("b_stable", {bvalid, bresp}, {1'b1, b_held});
      if (bvalid && bready) begin
        logic [1:0] eb;
        checks++;
        if (bq.size() == 0) begin
          errors++;
          $display("FAIL b_unexpected: got bresp=%b, required none", bresp);
        end else begin
          eb = bq.pop_front();
          $display("B resp=%b", bresp);
          if (bresp !== eb) begin
            errors++;
            $display("FAIL b_resp: got %b, expected %b", bresp, eb);
          end
        end
        b_stall = 0;
      end else if (bvalid) begin
        b_stall = 1;
        b_held  = bresp;
      end else begin
        b_stall = 0;
      end
    end
  end

  task automatic read_burst(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                            input logic [2:0] size, input int stall_beat, input int stall_cyc);
    int b, t, left;
    @(posedge clk); #1;
    araddr = addr; arlen = len; arburst = burst; arsize = size; arvalid = 1;
    t = 0;
    @(negedge clk);
    while (!arready && t < 50) begin @(negedge clk); t++; end
    if (!arready) begin expire("ar_timeout"); arvalid = 0; return; end
    left = stall_cyc;
    b = 0;
    @(posedge clk); ar_time = $time; #1;
    arvalid = 0;
    rready = !(stall_beat == 0 && left > 0);
    @(negedge clk);
    chk("r_latency", rvalid, 1);
    chk("arready_busy", arready, 0);
    if (rvalid) begin if (rready) b++; else left--; end
    t = 0;
    while (b <= int'(len) && t < 300) begin
      @(posedge clk); #1;
      rready = !(b == stall_beat && left > 0);
      @(negedge clk); t++;
      if (rvalid) begin if (rready) b++; else left--; end
    end
    @(posedge clk); #1;
    rready = 0;
    if (b <= int'(len)) expire("r_timeout");
  endtask

  task automatic write_burst(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                             input int nbeats, input int wlast_at, input int bdelay);
    int t;
    @(posedge clk); #1;
    awaddr = addr; awlen = len; awburst = burst; awvalid = 1;
    t = 0;
    @(negedge clk);
    while (!awready && t < 50) begin @(negedge clk); t++; end
    if (!awready) begin expire("aw_timeout"); awvalid = 0; return; end
    @(posedge clk); aw_time = $time; #1;
    awvalid = 0;
    for (int i = 0; i < nbeats; i++) begin
      wdata = wd[i]; wstrb = ws[i]; wlast = (i == wlast_at); wvalid = 1;
      t = 0;
      @(negedge clk);
      while (!wready && t < 50) begin @(negedge clk); t++; end
      if (!wready) begin expire("w_timeout"); wvalid = 0; wlast = 0; return; end
      @(posedge clk); #1;
    end
    wvalid = 0; wlast = 0;
    if (bdelay > 0) begin
      repeat (bdelay) @(posedge clk);
      #1;
      chk("bvalid_held", bvalid, 1);
    end
    bready = 1;
    t = 0;
    @(negedge clk);
    while (!bvalid && t < 50) begin @(negedge clk); t++; end
    if (!bvalid) expire("b_timeout");
    @(posedge clk); #1;
    bready = 0;
  endtask

  task automatic write1(input logic [31:0] addr, input logic [63:0] d, input logic [7:0] s,
                        input logic [1:0] exp_resp);
    wd[0] = d; ws[0] = s;
    bq.push_back(exp_resp);
    write_burst(addr, 8'd0, 2'b01, 1, 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #12;
    chk("rst_arready", arready, 0);
    chk("rst_awready", awready, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_wready", wready, 0);
    chk("rst_bvalid", bvalid, 0);
    @(posedge clk); #1; rst = 1;
    @(negedge clk);
    chk("idle_arready", arready, 1);
    chk("idle_awready", awready, 1);

    // Preload through the write channel
    write1(32'h8000_0000, 64'h1122_3344_5566_7788, 8'hFF, 2'b00);
    wd[0] = 64'hA5A5_0000_0000_0002; wd[1] = 64'hA5A5_0000_0000_0003;
    wd[2] = 64'hA5A5_0000_0000_0004; wd[3] = 64'hA5A5_0000_0000_0005;
    for (int i = 0; i < 4; i++) ws[i] = 8'hFF;
    bq.push_back(2'b00);
    write_burst(32'h8000_0010, 8'd3, 2'b01, 4, 3, 0);
    write1(32'h8000_0008, 64'h0, 8'hFF, 2'b00);
    write1(32'h8000_7FF8, 64'hFFFF_0000_FFFF_0000, 8'hFF, 2'b00);
    write1(32'h8000_0038, 64'h7777_7777_7777_7777, 8'hFF, 2'b00);

    // Strobed write, bready held off for 3 cycles
    wd[0] = 64'hFFFF_FFFF_FFFF_FFFF; ws[0] = 8'h0F;
    bq.push_back(2'b00);
    write_burst(32'h8000_0008, 8'd0, 2'b01, 1, 0, 3);

    // FIXED write burst: two beats merge into word 8
    wd[0] = 64'hAB00_0000_0000_0011; ws[0] = 8'hFF;
    wd[1] = 64'h0000_0000_0000_2200; ws[1] = 8'h02;
    bq.push_back(2'b00);
    write_burst(32'h8000_0040, 8'd1, 2'b00, 2, 1, 0);

    // Single read
    push_r(64'h1122_3344_5566_7788, 2'b00, 1'b1);
    read_burst(32'h8000_0000, 8'd0, 2'b01, 3'd3, -1, 0);
    push_r(64'h0000_0000_FFFF_FFFF, 2'b00, 1'b1);
    read_burst(32'h8000_0008, 8'd0, 2'b01, 3'd3, -1, 0);

    // INCR read with a 3-cycle stall on beat 1
    push_r(64'hA5A5_0000_0000_0002, 2'b00, 1'b0);
    push_r(64'hA5A5_0000_0000_0003, 2'b00, 1'b0);
    push_r(64'hA5A5_0000_0000_0004, 2'b00, 1'b0);
    push_r(64'hA5A5_0000_0000_0005, 2'b00, 1'b1);
    read_burst(32'h8000_0010, 8'd3, 2'b01, 3'd3, 1, 3);

    // Narrow INCR (4-byte steps) revisits word 0 then word 1
    push_r(64'h1122_3344_5566_7788, 2'b00, 1'b0);
    push_r(64'h1122_3344_5566_7788, 2'b00, 1'b0);
    push_r(64'h0000_0000_FFFF_FFFF, 2'b00, 1'b1);
    read_burst(32'h8000_0000, 8'd2, 2'b01, 3'd2, -1, 0);

    // FIXED read and unsupported burst
    push_r(64'hAB00_0000_0000_2211, 2'b00, 1'b0);
    push_r(64'hAB00_0000_0000_2211, 2'b00, 1'b1);
    read_burst(32'h8000_0040, 8'd1, 2'b00, 3'd3, -1, 0);
    push_r(64'h0, 2'b10, 1'b0);
    push_r(64'h0, 2'b10, 1'b1);
    read_burst(32'h8000_0000, 8'd1, 2'b10, 3'd3, -1, 0);

    // Range boundaries
    push_r(64'h0, 2'b10, 1'b1);
    read_burst(32'h7FFF_FFF8, 8'd0, 2'b01, 3'd3, -1, 0);
    push_r(64'hFFFF_0000_FFFF_0000, 2'b00, 1'b0);
    push_r(64'h0, 2'b10, 1'b1);
    read_burst(32'h8000_7FF8, 8'd1, 2'b01, 3'd3, -1, 0);
    write1(32'h7FFF_FFF8, 64'h1234, 8'hFF, 2'b10);

    // Early wlast: one beat lands, SLVERR, then a normal write still works
    wd[0] = 64'h6666_6666_6666_6666; ws[0] = 8'hFF;
    bq.push_back(2'b10);
    write_burst(32'h8000_0030, 8'd2, 2'b01, 1, 0, 0);
    chk("w_idle_after_err", awready, 1);
    push_r(64'h6666_6666_6666_6666, 2'b00, 1'b1);
    read_burst(32'h8000_0030, 8'd0, 2'b01, 3'd3, -1, 0);

    // Concurrent AR/AW to word 7
    push_r(64'h7777_7777_7777_7777, 2'b00, 1'b1);
    bq.push_back(2'b00);
    wd[0] = 64'h8888_8888_8888_8888; ws[0] = 8'hFF;
    fork
      read_burst(32'h8000_0038, 8'd0, 2'b01, 3'd3, -1, 0);
      write_burst(32'h8000_0038, 8'd0, 2'b01, 1, 0, 0);
    join
    chk("same_cycle_accept", 64'(ar_time), 64'(aw_time));
    push_r(64'h8888_8888_8888_8888, 2'b00, 1'b1);
    read_burst(32'h8000_0038, 8'd0, 2'b01, 3'd3, -1, 0);

    // Reset during beat 2 of a 4-beat read
    push_r(64'hA5A5_0000_0000_0002, 2'b00, 1'b0);
    push_r(64'hA5A5_0000_0000_0003, 2'b00, 1'b0);
    @(posedge clk); #1;
    araddr = 32'h8000_0010; arlen = 8'd3; arburst = 2'b01; arsize = 3'd3; arvalid = 1; rready = 1;
    @(negedge clk);
    chk("mid_arready", arready, 1);
    @(posedge clk); #1; arvalid = 0;
    @(posedge clk); #1;
    @(posedge clk); #1; rready = 0;
    @(negedge clk);
    chk("mid_beat2_valid", rvalid, 1);
    #2 rst = 0;
    #1;
    chk("mid_rvalid", rvalid, 0);
    chk("mid_rdata", rdata, 64'h0);
    chk("mid_arready_rst", arready, 0);
    chk("mid_beats_done", rq.size(), 0);
    rq.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1;
    @(negedge clk);
    chk("post_arready", arready, 1);
    chk("post_rvalid", rvalid, 0);
    push_r(64'h1122_3344_5566_7788, 2'b00, 1'b1);
    read_burst(32'h8000_0000, 8'd0, 2'b01, 3'd3, -1, 0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rq_drained", rq.size(), 0);
    chk("bq_drained", bq.size(), 0);
    chk("final_bvalid", bvalid, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
